// File: rtl/tile_renderer.sv
// Tile-map background renderer: turns display coordinates into RGB332 pixels through a
// fixed four-stage fetch pipeline (map/attribute -> pattern -> palette -> output).
module tile_renderer #(
  parameter logic [11:0] COLATTR_BASE = 12'h800,
  parameter logic        VSYNC_ACTIVE = 1'b0,
  parameter logic        HSYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        active,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [8:0]  scroll_x,
  input  logic [7:0]  scroll_y,
  output logic [11:0] map_read_addr,
  input  logic [7:0]  map_read_data,
  output logic [11:0] colattr_read_addr,
  input  logic [7:0]  colattr_read_data,
  output logic [10:0] tile_read_addr,
  input  logic [7:0]  tile_read_data,
  output logic [3:0]  color_read_addr,
  input  logic [7:0]  color_read_data,
  output logic [7:0]  rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_out
);

  logic [8:0] sx_l;
  logic [7:0] sy_l;
  logic       vs_prev;

  logic [8:0] lx, px;
  logic [7:0] ly, py;

  logic [2:0] fine_col0, fine_row0, fine_col1;
  logic [7:0] attr1;
  logic       act0, act1, act2;
  logic       hs0, hs1, hs2;
  logic       vs0, vs1, vs2;

  // Low bits are dropped by pixel doubling; y[9] never matters for 240 logical rows.
  logic unused_coord_bits;
  assign unused_coord_bits = ^{x[0], y[0], y[9]};

  always_comb begin
    lx = x[9:1];
    ly = y[8:1];
    px = lx + sx_l;
    py = ly + sy_l;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sx_l              <= '0;
      sy_l              <= '0;
      vs_prev           <= ~VSYNC_ACTIVE;
      map_read_addr     <= '0;
      colattr_read_addr <= '0;
      tile_read_addr    <= '0;
      color_read_addr   <= '0;
      fine_col0         <= '0;
      fine_row0         <= '0;
      fine_col1         <= '0;
      attr1             <= '0;
      act0              <= 1'b0;
      act1              <= 1'b0;
      act2              <= 1'b0;
      hs0               <= ~HSYNC_ACTIVE;
      hs1               <= ~HSYNC_ACTIVE;
      hs2               <= ~HSYNC_ACTIVE;
      vs0               <= ~VSYNC_ACTIVE;
      vs1               <= ~VSYNC_ACTIVE;
      vs2               <= ~VSYNC_ACTIVE;
      rgb               <= '0;
      hsync_out         <= ~HSYNC_ACTIVE;
      vsync_out         <= ~VSYNC_ACTIVE;
      active_out        <= 1'b0;
    end else begin
      // Scroll is taken only on the inactive->active vsync edge so a frame never tears.
      vs_prev <= vsync_in;
      if (vsync_in == VSYNC_ACTIVE && vs_prev != VSYNC_ACTIVE) begin
        sx_l <= scroll_x;
        sy_l <= scroll_y;
      end

      map_read_addr     <= {1'b0, py[7:3], px[8:3]};
      colattr_read_addr <= COLATTR_BASE + {1'b0, py[7:3], px[8:3]};
      fine_col0         <= px[2:0];
      fine_row0         <= py[2:0];
      act0              <= active;
      hs0               <= hsync_in;
      vs0               <= vsync_in;

      tile_read_addr <= {map_read_data, fine_row0};
      attr1          <= colattr_read_data;
      fine_col1      <= fine_col0;
      act1           <= act0;
      hs1            <= hs0;
      vs1            <= vs0;

      color_read_addr <= tile_read_data[3'd7 - fine_col1] ? attr1[7:4] : attr1[3:0];
      act2            <= act1;
      hs2             <= hs1;
      vs2             <= vs1;

      rgb        <= act2 ? color_read_data : 8'h00;
      hsync_out  <= hs2;
      vsync_out  <= vs2;
      active_out <= act2;
    end
  end

endmodule

// File: tb/tb_tile_renderer.sv
// Scoreboard bench for tile_renderer: stimulus queues expected values tagged with the
// cycle they are due; a negedge monitor compares and retires them.
module tb_tile_renderer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  x = '0, y = '0;
  logic        active = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [8:0]  scroll_x = '0;
  logic [7:0]  scroll_y = '0;
  logic [11:0] map_read_addr, colattr_read_addr;
  logic [7:0]  map_read_data, colattr_read_data, tile_read_data, color_read_data;
  logic [10:0] tile_read_addr;
  logic [3:0]  color_read_addr;
  logic [7:0]  rgb;
  logic        hsync_out, vsync_out, active_out;

  logic [7:0] attr_mem [4096];
  logic [7:0] tile_mem [2048];
  logic [7:0] color_mem [16];

  assign map_read_data     = attr_mem[map_read_addr];
  assign colattr_read_data = attr_mem[colattr_read_addr];
  assign tile_read_data    = tile_mem[tile_read_addr];
  assign color_read_data   = color_mem[color_read_addr];

  tile_renderer #(.COLATTR_BASE(12'h800), .VSYNC_ACTIVE(1'b0), .HSYNC_ACTIVE(1'b0)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .active(active),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .map_read_addr(map_read_addr), .map_read_data(map_read_data),
    .colattr_read_addr(colattr_read_addr), .colattr_read_data(colattr_read_data),
    .tile_read_addr(tile_read_addr), .tile_read_data(tile_read_data),
    .color_read_addr(color_read_addr), .color_read_data(color_read_data),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .active_out(active_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = {rgb,hsync,vsync,active}, 1 = map addr, 2 = colattr addr, 3 = tile addr, 4 = color addr
  typedef struct {
    int          due;
    int          kind;
    logic [11:0] val;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  int m_sx = 0, m_sy = 0;
  bit m_vsprev = 1'b1;

  task automatic push(input int ofs, input int kind, input logic [11:0] val);
    exp_t e;
    e.due  = cyc + ofs;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  function automatic logic [7:0] ref_rgb(input int xi, input int yi, input bit a,
                                         input int sx, input int sy);
    int px, py, idx;
    logic [7:0] t, at, p;
    if (!a) return 8'h00;
    px  = ((xi >> 1) + sx) % 512;
    py  = (((yi >> 1) & 255) + sy) % 256;
    idx = (py / 8) * 64 + (px / 8);
    t   = attr_mem[idx];
    at  = attr_mem[(2048 + idx) % 4096];
    p   = tile_mem[int'(t) * 8 + py % 8];
    return p[7 - px % 8] ? color_mem[at[7:4]] : color_mem[at[3:0]];
  endfunction

  task automatic step(input int xi, input int yi, input bit a, input bit h, input bit v,
                      input int sxi, input int syi, input bit auto_chk);
    @(negedge clk);
    rst      = 1'b0;
    x        = 10'(xi);
    y        = 10'(yi);
    active   = a;
    hsync_in = h;
    vsync_in = v;
    scroll_x = 9'(sxi);
    scroll_y = 8'(syi);
    if (auto_chk) push(4, 0, {1'b0, ref_rgb(xi, yi, a, m_sx, m_sy), h, v, a});
    if (!v && m_vsprev) begin
      m_sx = sxi % 512;
      m_sy = syi % 256;
    end
    m_vsprev = v;
  endtask

  task automatic rst_step();
    @(negedge clk);
    rst      = 1'b1;
    x        = 10'($urandom);
    y        = 10'($urandom);
    active   = 1'($urandom);
    hsync_in = 1'($urandom);
    vsync_in = 1'($urandom);
    scroll_x = 9'($urandom);
    scroll_y = 8'($urandom);
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due > cyc) sb.delete(i);
    for (int k = 1; k <= 4; k++) push(k, 0, 12'h006);
    push(1, 1, 12'h000);
    push(1, 2, 12'h000);
    push(1, 3, 12'h000);
    push(1, 4, 12'h000);
    m_sx = 0;
    m_sy = 0;
    m_vsprev = 1'b1;
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        logic [11:0] act;
        string nm;
        case (sb[i].kind)
          0: begin act = {1'b0, rgb, hsync_out, vsync_out, active_out}; nm = "pixel"; end
          1: begin act = map_read_addr;              nm = "map_addr"; end
          2: begin act = colattr_read_addr;          nm = "colattr_addr"; end
          3: begin act = {1'b0, tile_read_addr};     nm = "tile_addr"; end
          default: begin act = {8'h00, color_read_addr}; nm = "color_addr"; end
        endcase
        checks++;
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) attr_mem[i] = 8'(i) ^ 8'h5C;
    for (int i = 0; i < 2048; i++) tile_mem[i] = 8'(i * 37);
    for (int i = 0; i < 16; i++)   color_mem[i] = 8'(i * 17 + 3);
    attr_mem[12'h042] = 8'h41;
    attr_mem[12'h842] = 8'h5A;
    tile_mem[11'h209] = 8'b0100_0000;
    tile_mem[11'h20A] = 8'h00;
    color_mem[5]      = 8'hE0;
    color_mem[10]     = 8'h1C;
    attr_mem[12'h000] = 8'h07;
    attr_mem[12'h800] = 8'h3C;
    tile_mem[11'h03C] = 8'h10;
    color_mem[3]      = 8'h03;

    repeat (3) rst_step();

    // Foreground pixel fetch, scroll 0
    step(34, 18, 1, 1, 1, 0, 0, 0);
    push(1, 1, 12'h042);
    push(1, 2, 12'h842);
    push(2, 3, 12'h209);
    push(3, 4, 12'h005);
    push(4, 0, {1'b0, 8'hE0, 3'b111});

    // Background pixel, then the same pixel blanked with hsync asserted
    step(34, 20, 1, 1, 1, 0, 0, 0);
    push(2, 3, 12'h20A);
    push(3, 4, 12'h00A);
    push(4, 0, {1'b0, 8'h1C, 3'b111});
    step(34, 20, 0, 0, 1, 0, 0, 0);
    push(3, 4, 12'h00A);
    push(4, 0, {1'b0, 8'h00, 3'b010});

    // Out-of-range coordinates while active still wrap
    step(700, 20, 1, 1, 1, 0, 0, 1);
    step(639, 500, 1, 1, 1, 0, 0, 1);

    // Scroll latch on vsync falling edge, with wrap
    step(0, 0, 0, 1, 1, 500, 250, 1);
    step(0, 0, 0, 1, 0, 500, 250, 1);
    step(0, 0, 0, 1, 1, 500, 250, 1);
    step(30, 20, 1, 1, 1, 500, 250, 0);
    push(1, 1, 12'h000);
    push(1, 2, 12'h800);
    push(2, 3, 12'h03C);
    push(3, 4, 12'h003);
    push(4, 0, {1'b0, 8'h03, 3'b111});
    step(30, 20, 1, 1, 1, 0, 250, 0);
    push(1, 1, 12'h000);
    push(4, 0, {1'b0, 8'h03, 3'b111});
    step(0, 0, 0, 1, 0, 0, 250, 1);
    step(30, 20, 1, 1, 1, 0, 250, 1);
    push(1, 1, 12'h001);

    // Full streamed line with an hsync pulse
    for (int i = 0; i < 640; i++)
      step(i, 100, 1, !(i >= 600 && i < 620), 1, 0, 250, 1);

    // Reset for one clock in the middle of a line
    for (int i = 0; i < 200; i++) step(i, 101, 1, 1, 1, 0, 250, 1);
    rst_step();
    for (int i = 201; i < 260; i++) step(i, 101, 1, 1, 1, 0, 250, 1);

    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 0, 0, 1);
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
